logic_unit_scheduler: RTL and testbench
=======================================

Name: logic_unit_scheduler

Overview:
- Shares one 8-bit bitwise logic unit (OR/AND/XOR/NOR) between NUM_REQ requesters using a round-robin arbiter.
- Each requester presents two operands and an opcode with a valid/ready handshake.
- The block latches the winner's operands, computes the result in a registered stage, and returns it with the winner's index.
- Sits between the DSP control sequencer and the bitwise datapath; it is the only path by which requesters reach the logic function.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- ID_W, 2, width of requester index; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req_Valid  input  NUM_REQ  bit i = requester i has a pending operation.
- Req_Ready  output  NUM_REQ  one-hot grant; bit i high = requester i accepted this cycle.
- Req_A  input  WIDTH*NUM_REQ  operand A, requester i at bits [i*WIDTH +: WIDTH].
- Req_B  input  WIDTH*NUM_REQ  operand B, same packing as Req_A.
- Req_Op  input  2*NUM_REQ  opcode, requester i at [2*i +: 2]. 00=OR, 01=AND, 10=XOR, 11=NOR.
- Res_Valid  output  1  result available.
- Res_Ready  input  1  consumer accepts result.
- Res_Data  output  WIDTH  operation result.
- Res_Id  output  ID_W  index of the requester that owns Res_Data.
- Busy  output  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock (Clk); Reset is synchronous and active-high.
- On Reset: state=IDLE, priority pointer Ptr=0, Res_Valid=0, Res_Data=0, Res_Id=0, Busy=0, Req_Ready=0. Operand latches are cleared to 0.
- Reset mid-operation aborts the operation; no result is produced and the pending requester is not re-granted automatically.
- States: IDLE, EXEC, RESP.
- IDLE:
  - If any Req_Valid bit is set, pick the winner w: the first set bit searching Ptr, Ptr+1, ... with wrap modulo NUM_REQ.
  - Req_Ready[w]=1 combinationally in that cycle only; this is the accept cycle T.
  - Latch A, B, Op and the index of w. Set Ptr <= (w+1) mod NUM_REQ. Next state = EXEC.
  - If no Req_Valid bit is set, stay in IDLE, Req_Ready=0, Ptr unchanged.
- EXEC (cycle T+1):
  - Register Res_Data = op(A,B), with NOR = ~(A|B). Register Res_Id = latched index. Set Res_Valid=1. Next state = RESP.
- RESP (cycle T+2 onward):
  - Res_Valid, Res_Data and Res_Id are held stable until Res_Valid && Res_Ready.
  - On that handshake, Res_Valid <= 0 and next state = IDLE (see optional feature).
- Latency: accept at T gives Res_Valid high at T+2. Minimum issue interval is 3 cycles.
- Req_Ready is 0 in EXEC and RESP. A requester that drops Req_Valid before being granted is simply skipped; nothing is latched for it.
- Fairness: a continuously-asserting requester waits at most NUM_REQ-1 grants.
- Res_Ready high while Res_Valid=0 has no effect.
- Req_Valid bits at index >= NUM_REQ do not exist; Ptr never exceeds NUM_REQ-1.

Optional Feature:
- Macro: LU_BACK2BACK_EN.
- Defined: in RESP, during the cycle where Res_Valid && Res_Ready, the arbiter also evaluates Req_Valid using the same Ptr rule.
  - If a winner exists, assert its Req_Ready that cycle, latch its operands, update Ptr and go directly to EXEC.
  - The new Res_Valid rises 2 cycles after the previous handshake, giving an issue interval of 2 cycles.
  - If no winner exists, go to IDLE.
- Undefined: RESP always returns to IDLE; Req_Ready is never asserted outside IDLE.

Test Plan:
- Reset check: assert Reset 2 cycles with Req_Valid=4'b1111 -> Req_Ready=0, Res_Valid=0, Res_Data=0, Busy=0; first grant after release goes to requester 0.
- Single op: requester 2 sends A=8'hA5, B=8'h0F, Op=00 at cycle T -> Req_Ready=4'b0100 at T; Res_Valid at T+2 with Res_Data=8'hAF, Res_Id=2. Repeat with Op=01/10/11 -> 8'h05, 8'hAA, 8'h50.
- Round-robin: hold Req_Valid=4'b1011 with Res_Ready=1 -> grant order 0,1,3,0,1,3, each accept 3 cycles apart (2 cycles with LU_BACK2BACK_EN).
- Backpressure: hold Res_Ready=0 for 5 cycles after Res_Valid -> Res_Data and Res_Id stable, Req_Ready=0, Busy=1; release -> Res_Valid falls the next cycle.
- Reset mid-op: assert Reset in EXEC for requester 1 -> no Res_Valid afterward, Ptr=0; with Req_Valid=4'b0010 still high, requester 1 is re-granted after reset.
- Withdrawn request: Req_Valid[3] pulses for one cycle while the block is in RESP -> requester 3 is never granted and no result with Res_Id=3 appears.

Source files
------------

// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler sharing one registered OR/AND/XOR/NOR unit between NUM_REQ requesters.
// Define LU_BACK2BACK_EN to let a result handshake accept the next request in the same cycle.

module logic_unit_scheduler_lane #(
  parameter int ID_W = 2,
  parameter int IDX  = 0
) (
  input  logic            vld,
  input  logic [ID_W-1:0] ptr,
  output logic            hi
);
  // Requester sits at or above the pointer: first pass of the wrap-around search.
  assign hi = vld && (ptr <= ID_W'(IDX));
endmodule

module logic_unit_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       Req_Valid,
  output logic [NUM_REQ-1:0]       Req_Ready,
  input  logic [WIDTH*NUM_REQ-1:0] Req_A,
  input  logic [WIDTH*NUM_REQ-1:0] Req_B,
  input  logic [2*NUM_REQ-1:0]     Req_Op,
  output logic                     Res_Valid,
  input  logic                     Res_Ready,
  output logic [WIDTH-1:0]         Res_Data,
  output logic [ID_W-1:0]          Res_Id,
  output logic                     Busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [ID_W-1:0]  id;
  } req_t;

  state_t             state, state_nx;
  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] hi;
  logic [ID_W-1:0]    win;
  logic               any;
  logic               accept;
  req_t               req_q;
  logic [WIDTH-1:0]   res_nx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      logic_unit_scheduler_lane #(.ID_W(ID_W), .IDX(gi)) u_lane (
        .vld (Req_Valid[gi]),
        .ptr (ptr),
        .hi  (hi[gi])
      );
    end
  endgenerate

  // Lowest set bit at/above ptr wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    logic found;
    win   = '0;
    found = 1'b0;
    any   = |Req_Valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && hi[i]) begin
        win   = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && Req_Valid[i]) begin
        win   = ID_W'(i);
        found = 1'b1;
      end
    end
  end

`ifdef LU_BACK2BACK_EN
  assign accept = !Reset && any &&
                  (state == IDLE || (state == RESP && Res_Valid && Res_Ready));
`else
  assign accept = !Reset && any && (state == IDLE);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (any) state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: if (Res_Valid && Res_Ready) begin
`ifdef LU_BACK2BACK_EN
        state_nx = any ? EXEC : IDLE;
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Req_Ready = '0;
    if (accept) Req_Ready[win] = 1'b1;
    Busy = (state != IDLE);
  end

  always_comb begin
    case (req_q.op)
      2'b00:   res_nx = req_q.a | req_q.b;
      2'b01:   res_nx = req_q.a & req_q.b;
      2'b10:   res_nx = req_q.a ^ req_q.b;
      default: res_nx = ~(req_q.a | req_q.b);
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr       <= '0;
      req_q     <= '0;
      Res_Valid <= 1'b0;
      Res_Data  <= '0;
      Res_Id    <= '0;
    end else begin
      if (accept) begin
        req_q.a  <= Req_A[win*WIDTH +: WIDTH];
        req_q.b  <= Req_B[win*WIDTH +: WIDTH];
        req_q.op <= Req_Op[win*2 +: 2];
        req_q.id <= win;
        ptr      <= (int'(win) == NUM_REQ-1) ? '0 : win + 1'b1;
      end
      if (state == EXEC) begin
        Res_Data  <= res_nx;
        Res_Id    <= req_q.id;
        Res_Valid <= 1'b1;
      end else if (state == RESP && Res_Ready) begin
        Res_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Directed bench for logic_unit_scheduler: ops, round-robin order, backpressure, resets, withdrawn requests.
module tb_logic_unit_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;
`ifdef LU_BACK2BACK_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  logic                     Clk;
  logic                     Reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic [2*NUM_REQ-1:0]     req_op;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_data;
  logic [ID_W-1:0]          res_id;
  logic                     busy;

  int n_chk = 0;
  int n_err = 0;

  logic_unit_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req_Valid (req_valid),
    .Req_Ready (req_ready),
    .Req_A     (req_a),
    .Req_B     (req_b),
    .Req_Op    (req_op),
    .Res_Valid (res_valid),
    .Res_Ready (res_ready),
    .Res_Data  (res_data),
    .Res_Id    (res_id),
    .Busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*2 +: 2]        = op;
  endtask

  // Issues one op from an idle block with Res_Ready held high.
  task automatic single_op(input string tag, input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op, input logic [7:0] exp);
    step;
    req_valid = NUM_REQ'(1) << i;
    set_op(i, a, b, op);
    smp;
    chk($sformatf("%s_rdy", tag), 32'(req_ready), 32'(NUM_REQ'(1) << i));
    step;
    req_valid = '0;
    smp;
    chk($sformatf("%s_t1_vld", tag), 32'(res_valid), 0);
    chk($sformatf("%s_t1_busy", tag), 32'(busy), 1);
    step;
    smp;
    chk($sformatf("%s_vld", tag), 32'(res_valid), 1);
    chk($sformatf("%s_data", tag), 32'(res_data), 32'(exp));
    chk($sformatf("%s_id", tag), 32'(res_id), 32'(i));
    step;
    smp;
    chk($sformatf("%s_done_vld", tag), 32'(res_valid), 0);
    chk($sformatf("%s_done_busy", tag), 32'(busy), 0);
  endtask

  initial begin
    int exp_rr[6] = '{0, 1, 3, 0, 1, 3};
    int gidx[6];
    int gcyc[6];
    int ng;
    int seen3;
    int bad3;

    Reset     = 1'b1;
    req_valid = '1;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;

    // reset with all requesters asserting
    step; step;
    smp;
    chk("rst_rdy", 32'(req_ready), 0);
    chk("rst_vld", 32'(res_valid), 0);
    chk("rst_data", 32'(res_data), 0);
    chk("rst_busy", 32'(busy), 0);
    step;
    Reset = 1'b0;
    smp;
    chk("rst_first_grant", 32'(req_ready), 32'h1);
    step;
    req_valid = '0;
    res_ready = 1'b1;
    step; step;

    single_op("op_or",  2, 8'hA5, 8'h0F, 2'b00, 8'hAF);
    single_op("op_and", 2, 8'hA5, 8'h0F, 2'b01, 8'h05);
    single_op("op_xor", 2, 8'hA5, 8'h0F, 2'b10, 8'hAA);
    single_op("op_nor", 2, 8'hA5, 8'h0F, 2'b11, 8'h50);

    // round-robin from a fresh pointer
    step;
    Reset = 1'b1;
    step;
    Reset     = 1'b0;
    req_valid = 4'b1011;
    res_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      smp;
      if (req_ready != '0) begin
        for (int j = 0; j < NUM_REQ; j++) if (req_ready[j]) gidx[ng] = j;
        gcyc[ng] = c;
        ng++;
      end
    end
    step;
    req_valid = '0;
    step; step; step;
    chk("rr_count", 32'(ng), 6);
    for (int k = 0; k < ng; k++) begin
      chk($sformatf("rr_id%0d", k), 32'(gidx[k]), 32'(exp_rr[k]));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'(GAP));
    end

    // backpressure on requester 1
    res_ready = 1'b0;
    step;
    req_valid = 4'b0010;
    set_op(1, 8'h3C, 8'hF0, 2'b10);
    smp;
    chk("bp_grant", 32'(req_ready), 32'h2);
    step;
    req_valid = '0;
    step;
    smp;
    chk("bp_vld", 32'(res_valid), 1);
    chk("bp_data", 32'(res_data), 32'hCC);
    chk("bp_id", 32'(res_id), 1);
    step;
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      smp;
      chk("bp_hold_vld", 32'(res_valid), 1);
      chk("bp_hold_data", 32'(res_data), 32'hCC);
      chk("bp_hold_id", 32'(res_id), 1);
      chk("bp_hold_rdy", 32'(req_ready), 0);
      chk("bp_hold_busy", 32'(busy), 1);
      step;
    end
    res_ready = 1'b1;
    req_valid = '0;
    smp;
    chk("bp_hs_vld", 32'(res_valid), 1);
    step;
    smp;
    chk("bp_release_vld", 32'(res_valid), 0);

    // reset during EXEC for requester 1
    step;
    req_valid = 4'b0010;
    set_op(1, 8'hFF, 8'h0F, 2'b01);
    smp;
    chk("rm_grant", 32'(req_ready), 32'h2);
    step;
    Reset = 1'b1;
    smp;
    chk("rm_rdy_in_rst", 32'(req_ready), 0);
    step;
    Reset = 1'b0;
    smp;
    chk("rm_no_vld", 32'(res_valid), 0);
    chk("rm_regrant", 32'(req_ready), 32'h2);
    step;
    req_valid = '0;
    smp;
    chk("rm_t1_vld", 32'(res_valid), 0);
    step;
    smp;
    chk("rm_res_vld", 32'(res_valid), 1);
    chk("rm_res_id", 32'(res_id), 1);
    chk("rm_res_data", 32'(res_data), 32'h0F);
    step;
    smp;
    chk("rm_done_vld", 32'(res_valid), 0);

    // requester 3 pulses valid for one cycle while a result is stalled
    res_ready = 1'b0;
    step;
    req_valid = 4'b0001;
    set_op(0, 8'h55, 8'hAA, 2'b00);
    set_op(3, 8'h12, 8'h34, 2'b00);
    smp;
    chk("wd_grant0", 32'(req_ready), 32'h1);
    step;
    req_valid = '0;
    step;
    req_valid = 4'b1000;
    smp;
    chk("wd_rdy_resp", 32'(req_ready), 0);
    chk("wd_data", 32'(res_data), 32'hFF);
    chk("wd_id", 32'(res_id), 0);
    step;
    req_valid = '0;
    res_ready = 1'b1;
    seen3 = 0;
    bad3  = 0;
    for (int k = 0; k < 8; k++) begin
      smp;
      if (req_ready[3]) seen3++;
      if (res_valid && res_id == 2'd3) bad3++;
      step;
    end
    chk("wd_no_grant3", 32'(seen3), 0);
    chk("wd_no_id3", 32'(bad3), 0);
    chk("wd_idle_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
